corr_peak_detector: RTL

//   Downstream stage of the RX correlator moving-sum integrator. Watches the integrated

---
 rtl/corr_peak_detector.sv | 88 ++++++++
 1 files changed

// File: rtl/corr_peak_detector.sv
// corr_peak_detector: reports max value/timestamp of each above-threshold excursion (clk, active-low sync rst, enable, in_valid, data_in, threshold -> peak_valid, peak_value, peak_time, busy)
module corr_peak_detector #(
  parameter int DATA_WIDTH = 14,
  parameter int TS_WIDTH   = 16,
  parameter int MAX_WIN    = 32,
  parameter int HOLDOFF    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  peak_valid,
  output logic [DATA_WIDTH-1:0] peak_value,
  output logic [TS_WIDTH-1:0]   peak_time,
  output logic                  busy
);
  localparam int RW = $clog2(MAX_WIN + 1);
  localparam int HW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
  state_t                state, state_n;
  logic [TS_WIDTH-1:0]   ts, max_ts, max_ts_n;
  logic [DATA_WIDTH-1:0] max_v, max_n;
  logic [RW-1:0]         run, run_n;
  logic [HW-1:0]         hold, hold_n;
  logic                  above, report;
  assign above = data_in > threshold;
  always_comb begin
    state_n  = state;
    max_n    = max_v;
    max_ts_n = max_ts;
    run_n    = run;
    hold_n   = hold;
    report   = 1'b0;
    if (!enable) state_n = IDLE;
    else if (in_valid) begin
      if (state == IDLE && above) begin
        max_n    = data_in;
        max_ts_n = ts;
        run_n    = RW'(1);
        state_n  = TRACK;
        report   = (MAX_WIN == 1);
      end
      if (state == TRACK) begin
        run_n = run + 1'b1;
        if (above && data_in > max_v) begin
          max_n    = data_in;
          max_ts_n = ts;
        end
        report = !above || run_n == RW'(MAX_WIN);
      end
      if (state == HOLD) begin
        hold_n  = hold - 1'b1;
        state_n = hold == HW'(1) ? IDLE : HOLD;
      end
      if (report) begin
        state_n = HOLDOFF == 0 ? IDLE : HOLD;
        hold_n  = HW'(HOLDOFF);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ts         <= '0;
      max_v      <= '0;
      max_ts     <= '0;
      run        <= '0;
      hold       <= '0;
      peak_valid <= 1'b0;
      peak_value <= '0;
      peak_time  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      ts         <= in_valid ? ts + 1'b1 : ts;
      max_v      <= max_n;
      max_ts     <= max_ts_n;
      run        <= run_n;
      hold       <= hold_n;
      peak_valid <= report;
      peak_value <= report ? max_n : peak_value;
      peak_time  <= report ? max_ts_n : peak_time;
      busy       <= state_n != IDLE;
    end
  end
endmodule
